uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
//  Read-side controller for the UART TX FIFO (non-FWFT; read data valid only while rd_en high).
//  Pops one word at a time, offers it to the UART transmitter on a valid/ready handshake,
//  waits for frame completion, then inserts a programmable idle gap.
//  Gates frame starts on enable and optional CTS flow control; counts frames sent.
// PARAMETERS
//  DataWidth  8   FIFO word / UART frame payload width
//  GapWidth   8   width of i_gap_cycles (inter-frame idle, in i_clk cycles)
//  FlowCtrl   1   1: frame start requires synchronised i_cts_n==0; 0: i_cts_n ignored
//  CntWidth   16  width of o_frame_cnt
// PORTS
//  i_clk          in   1          system clock
//  i_rst_n        in   1          async active-low reset
//  i_enable       in   1          1 = allow new frame starts
//  i_cts_n        in   1          clear-to-send, active low, asynchronous pin
//  i_gap_cycles   in   GapWidth   idle cycles after each frame (0 = none)
//  i_fifo_empty   in   1          TX FIFO empty
//  i_fifo_rd_data in   DataWidth  TX FIFO read data (valid in o_fifo_rd_en cycle)
//  o_fifo_rd_en   out  1          FIFO pop strobe
//  o_tx_data      out  DataWidth  word offered to transmitter
//  o_tx_valid     out  1          o_tx_data valid
//  i_tx_ready     in   1          transmitter can accept a word
//  i_tx_done      in   1          1-cycle pulse: stop bit of current frame finished
//  o_busy         out  1          1 in any state except IDLE
//  o_frame_cnt    out  CntWidth   frames completed (i_tx_done seen in WAIT_DONE), wraps
// BEHAVIOUR
//  Clock i_clk; reset is asynchronous, active-low on i_rst_n.
//  Reset: state=IDLE; o_fifo_rd_en=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_frame_cnt=0,
//   CTS synchroniser flops=1 (deasserted).
//  cts_ok = FlowCtrl ? (cts_n_sync==0) : 1; cts_n_sync = i_cts_n after 2 flops.
//  IDLE: if i_enable && !i_fifo_empty && cts_ok -> FETCH.
//  FETCH (exactly 1 cycle): o_fifo_rd_en=1 (decoded from state);
//   data_q <= i_fifo_rd_data at same edge; -> OFFER.
//  OFFER: o_tx_valid=1, o_tx_data=data_q; on edge with i_tx_ready=1 -> WAIT_DONE.
//   o_tx_data stable while valid; valid never drops without ready.
//  WAIT_DONE: o_tx_valid=0; on i_tx_done: o_frame_cnt+1 (mod 2^CntWidth);
//   if i_gap_cycles==0 -> IDLE else load gap_cnt=i_gap_cycles -> GAP.
//  GAP: gap_cnt-1 per cycle; when gap_cnt==1 -> IDLE (GAP lasts exactly i_gap_cycles).
//  o_tx_data retains last value outside OFFER.
//  Latency: IDLE sees start condition in cycle N -> rd_en cycle N+1 -> tx_valid cycle N+2.
//  i_enable / cts_ok sampled only in IDLE: deassertion mid-frame never aborts a frame;
//   the popped word is always delivered.
//  i_fifo_empty ignored outside IDLE; FETCH never issued when empty (no underflow).
//  i_tx_done outside WAIT_DONE ignored (no count).
//  i_tx_ready in the cycle that enters OFFER: accepted at the first OFFER edge (min 1 cycle valid).
//  i_gap_cycles sampled only on WAIT_DONE exit; changes during GAP have no effect.
//  Back-to-back, gap=0: next FETCH cycle follows the IDLE cycle after done (>=1 idle cycle).
//  Async reset mid-frame: immediate IDLE, outputs to reset values; the popped word is lost.
// STRUCTURE
//  uart_pkg: typedef enum logic [2:0] {IDLE,FETCH,OFFER,WAIT_DONE,GAP} tx_sched_state_e.
//  Sub-module: sync_2ff (2-flop synchroniser, reset value parameter) for i_cts_n.
//  Single always_ff for state/data_q/gap_cnt/frame_cnt; output decode in always_comb.
// TESTING
//  1 FIFO holds 0xA5, enable=1, FlowCtrl=0, ready=1 -> rd_en 1 cycle, tx_valid with 0xA5
//    2 cycles after start; done pulse -> frame_cnt=1, busy=0.
//  2 3 words 0x01,0x02,0x03, gap=4 -> frames in order; 4 GAP cycles between each done and
//    the next IDLE; frame_cnt=3; rd_en pulses=3.
//  3 ready held 0 for 10 cycles in OFFER -> tx_valid and tx_data stable all 10 cycles;
//    no second rd_en.
//  4 FlowCtrl=1, cts_n=1 with data queued -> no rd_en; cts_n->0 -> rd_en 3 cycles later
//    (2 sync + IDLE); cts_n->1 during WAIT_DONE -> frame completes, then no new fetch.
//  5 enable dropped in OFFER -> word still sent, counted; stays IDLE after.
//    Async reset in WAIT_DONE -> outputs reset, frame_cnt=0.
//  6 frame_cnt preloaded path: 2^CntWidth frames (CntWidth=4 build) -> wraps 15->0;
//    empty FIFO in IDLE -> rd_en never asserted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART TX FIFO read-side scheduler.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      OFFER     = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } tx_sched_state_e;

endpackage

// File: rtl/uart_tx_sched_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
module sync_2ff #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= ResetVal;
         q    <= ResetVal;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Read-side controller for the UART TX FIFO: pops one word, offers it to the
// transmitter on valid/ready, waits for frame completion, then idles for a gap.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned DataWidth = 8,
   parameter int unsigned GapWidth  = 8,
   parameter bit          FlowCtrl  = 1'b1,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_enable,
   input  logic                 i_cts_n,
   input  logic [GapWidth-1:0]  i_gap_cycles,
   input  logic                 i_fifo_empty,
   input  logic [DataWidth-1:0] i_fifo_rd_data,
   output logic                 o_fifo_rd_en,
   output logic [DataWidth-1:0] o_tx_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   input  logic                 i_tx_done,
   output logic                 o_busy,
   output logic [CntWidth-1:0]  o_frame_cnt
);

   tx_sched_state_e      state;
   logic [DataWidth-1:0] data_q;
   logic [GapWidth-1:0]  gap_cnt;
   logic [CntWidth-1:0]  frame_cnt;
   logic                 cts_n_sync;
   logic                 cts_ok_c;

   // CTS pin is asynchronous; resets to deasserted so no frame starts before it settles.
   sync_2ff #(
      .ResetVal (1'b1)
   ) u_cts_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .d     (i_cts_n),
      .q     (cts_n_sync)
   );

   assign cts_ok_c = !FlowCtrl || !cts_n_sync;

   // Scheduler state, captured word, gap countdown and frame counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         gap_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_enable && !i_fifo_empty && cts_ok_c) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               // Non-FWFT FIFO: data is valid only during the pop cycle.
               data_q <= i_fifo_rd_data;
               state  <= OFFER;
            end
            OFFER: begin
               if (i_tx_ready) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_tx_done) begin
                  frame_cnt <= frame_cnt + CntWidth'(1);
                  if (i_gap_cycles == '0) begin
                     state <= IDLE;
                  end else begin
                     gap_cnt <= i_gap_cycles;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - GapWidth'(1);
               if (gap_cnt == GapWidth'(1)) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes decoded straight from the state register.
   always_comb begin
      o_fifo_rd_en = 1'b0;
      o_tx_valid   = 1'b0;
      o_busy       = (state != IDLE);
      case (state)
         FETCH:   o_fifo_rd_en = 1'b1;
         OFFER:   o_tx_valid   = 1'b1;
         default: ;
      endcase
   end

   assign o_tx_data   = data_q;
   assign o_frame_cnt = frame_cnt;

endmodule
